// File: rtl/bit_chunk_tracker.sv
// Accumulates per-cycle bit advances into word-sized chunks and queues closed-chunk records.
// Latency: a record pushed at edge N is presented (out_valid=1) right after edge N, first-word-fall-through.
// Backpressure: records wait in a DEPTH-entry FIFO; a record arriving while full with no pop is dropped and sets overflow.

module bct_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_dat,
   input  logic             pop,
   output logic [W-1:0]     head_dat,
   output logic [LVL_W-1:0] level,
   output logic             dropped
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [IDX_W-1:0] wr_ptr;
   logic [IDX_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      do_pop   = pop & (level != '0);
      do_push  = push & ((level != LVL_W'(DEPTH)) | do_pop);
      dropped  = push & ~do_push;
      head_dat = mem[rd_ptr];
   end

   // Storage is not reset; the level counter alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH, which need not be a power of two.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == IDX_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end
endmodule

module bit_chunk_tracker #(
   parameter int WORD_W = 64,
   parameter int ADV_W  = 5,
   parameter int ALIGN  = 8,
   parameter int DEPTH  = 4,
   parameter int ACC_W  = $clog2(WORD_W) + 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clk_en,
   input  logic [ADV_W-1:0]           advance,
   input  logic                       align,
   input  logic                       seg_start,
   input  logic                       start_loc,
   input  logic                       mark_in,
   input  logic                       flush,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [ACC_W-1:0]           out_cnt,
   output logic                       out_first,
   output logic                       out_mark,
   output logic                       out_last,
   output logic [$clog2(DEPTH+1)-1:0] fill_level,
   output logic                       overflow
);
   localparam int PH_W  = (ALIGN > 1) ? $clog2(ALIGN) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [ACC_W-1:0] cnt;
      logic             first;
      logic             mark;
      logic             last;
   } rec_t;

   logic [ACC_W-1:0] acc;
   logic [PH_W-1:0]  phase;
   logic             first_reg;
   logic             mark_reg;

   logic [ACC_W-1:0] adv_ext;
   logic [ACC_W-1:0] pad;
   logic [ACC_W-1:0] inc;
   logic [ACC_W-1:0] acc_nxt;
   logic [PH_W-1:0]  phase_nxt;
   logic             rec_gen;
   rec_t             rec;
   rec_t             head;
   logic             push;
   logic             pop;
   logic             dropped;

   // Chunk-close decision: segment start beats flush beats word fill; a filled
   // chunk is only closed the cycle after the registered count reaches WORD_W.
   always_comb begin
      adv_ext   = ACC_W'(advance);
      pad       = ACC_W'(ALIGN) - ACC_W'(phase);
      inc       = align ? pad : adv_ext;
      phase_nxt = PH_W'((ACC_W'(phase) + adv_ext) & ACC_W'(ALIGN - 1));
      rec.cnt   = acc;
      rec.first = first_reg;
      rec.mark  = mark_reg;
      rec.last  = 1'b0;
      rec_gen   = 1'b0;
      acc_nxt   = acc + inc;
      if (seg_start) begin
         // The boundary bit itself opens the new chunk when start_loc is set.
         rec.cnt = start_loc ? (acc + adv_ext - ACC_W'(1)) : acc;
         acc_nxt = start_loc ? ACC_W'(1) : adv_ext;
         rec_gen = 1'b1;
      end else if (flush) begin
         rec.cnt  = acc + inc;
         rec.last = 1'b1;
         acc_nxt  = '0;
         rec_gen  = (rec.cnt != '0);
      end else if (acc >= ACC_W'(WORD_W)) begin
         acc_nxt = inc;
         rec_gen = 1'b1;
      end
      push = clk_en & rec_gen;
      pop  = out_valid & out_ready;
   end

   // Input-side state only moves on enabled cycles; flags raised in a close cycle carry into the next chunk.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc       <= '0;
         phase     <= '0;
         first_reg <= 1'b0;
         mark_reg  <= 1'b0;
      end else if (clk_en) begin
         acc       <= acc_nxt;
         phase     <= align ? '0 : phase_nxt;
         first_reg <= seg_start | (first_reg & ~rec_gen);
         mark_reg  <= mark_in | (mark_reg & ~rec_gen);
      end
   end

   // Sticky drop indicator, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (dropped) begin
         overflow <= 1'b1;
      end
   end

   bct_fifo #(
      .W     ($bits(rec_t)),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_dat (rec),
      .pop      (pop),
      .head_dat (head),
      .level    (fill_level),
      .dropped  (dropped)
   );

   // Record fields read as zero whenever nothing is queued.
   always_comb begin
      out_valid = (fill_level != '0);
      out_cnt   = out_valid ? head.cnt   : '0;
      out_first = out_valid & head.first;
      out_mark  = out_valid & head.mark;
      out_last  = out_valid & head.last;
   end
endmodule
